pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the five-stage CPU datapath. It replaces per-stage hand-written latches with one block that carries an opaque payload of DATA_W bits between stages. Stages handshake with valid/ready, a synchronous flush squashes in-flight work, and an optional two-entry skid buffer breaks the combinational ready path. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). The payload is a packed struct defined per boundary.

---
 rtl/pipe_pkg.sv | 72 +++++++
 rtl/pipe_slot.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
// Holds the occupancy-state enum, the occupancy width, and the
// per-boundary payload structs that size each pipe_stage_reg instance.
package pipe_pkg;

  // Occupancy of a stage register: no entry, main slot only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Width of the occ output (counts 0..2).
  localparam int OCC_W = 2;

  // IF/ID boundary payload: fetched instruction and its address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  // ID/EX boundary payload: decoded operands and control.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        mem_we;
    logic        mem_re;
    logic        reg_we;
  } idex_t;

  // EX/MEM boundary payload: ALU result and memory request.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_we;
    logic        mem_re;
    logic        reg_we;
  } exmem_t;

  // MEM/WB boundary payload: value to write back.
  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } memwb_t;

  // Payload widths used as DATA_W for each boundary instance.
  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  // Number of entries held in a given occupancy state.
  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
    logic [OCC_W-1:0] n;
    n = '0;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage register: a DATA_W payload
// register with a valid bit. clear wins over load, load wins over drop.
// clear returns the payload to RST_VAL; drop only invalidates, so the
// payload keeps showing the last value that left the slot.
module pipe_slot #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  // Slot state: async reset, then squash, fill, or invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (clear) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (drop) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying an opaque DATA_W payload.
// Main slot M drives the outputs. With PIPE_STAGE_SKID_EN defined a second
// skid slot S absorbs one extra payload so in_ready comes from a flop;
// without it only M exists and in_ready is combinational from out_ready.
// flush squashes both slots to RST_VAL and drops any same-cycle input.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occ
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_load;
  logic              m_drop;
  logic [DATA_W-1:0] m_load_data;
  logic              s_valid;
  logic              in_xfer;
  logic              out_xfer;
  stage_state_t      state;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = m_valid && out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  // Occupancy state follows directly from the slot valid bits.
  always_comb begin
    state = EMPTY;
    if (s_valid) begin
      state = FULL;
    end else if (m_valid) begin
      state = ONE;
    end
  end

  assign occ = occ_of(state);

  // Main slot: always present, drives the downstream interface.
  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_slot_m (
    .clk       (CLK),
    .rst       (RST),
    .clear     (flush),
    .load      (m_load),
    .drop      (m_drop),
    .load_data (m_load_data),
    .valid     (m_valid),
    .data      (m_data)
  );

`ifdef PIPE_STAGE_SKID_EN

  logic              s_load;
  logic              s_drop;
  logic [DATA_W-1:0] s_data;

  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready = !s_valid;

  // Skid slot: catches the payload that arrives while M is stalled.
  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_slot_s (
    .clk       (CLK),
    .rst       (RST),
    .clear     (flush),
    .load      (s_load),
    .drop      (s_drop),
    .load_data (in_data),
    .valid     (s_valid),
    .data      (s_data)
  );

  // Next-slot control for the two-entry occupancy machine.
  always_comb begin
    m_load      = 1'b0;
    m_drop      = 1'b0;
    m_load_data = in_data;
    s_load      = 1'b0;
    s_drop      = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m_load = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_load = 1'b1;
          end else if (in_xfer) begin
            s_load = 1'b1;
          end else if (out_xfer) begin
            m_drop = 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain of M can happen.
          if (out_xfer) begin
            m_load      = 1'b1;
            m_load_data = s_data;
            s_drop      = 1'b1;
          end
        end
        default: begin
          m_load = 1'b0;
        end
      endcase
    end
  end

`else

  // Single-slot build: accept whenever M is free or being drained.
  assign s_valid  = 1'b0;
  assign in_ready = out_ready || !m_valid;

  // Next-slot control: a same-cycle in/out transfer simply replaces M.
  always_comb begin
    m_load_data = in_data;
    m_load      = !flush && in_xfer;
    m_drop      = !flush && out_xfer && !in_xfer;
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DATA_W=32, RST_VAL=DEADBEEF).
// Works with and without PIPE_STAGE_SKID_EN; a FIFO-queue reference model
// predicts the outputs each cycle, directed tests pin literal values.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_data;
  logic [OCC_W-1:0]  occ;

  pipe_stage_reg #(
    .DATA_W  (32),
    .RST_VAL (RV)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted payloads in order, plus last value to leave.
  logic [31:0] q[$];
  logic [31:0] last_out = RV;
  logic        m_ir;

  function automatic logic model_in_ready();
    if (SKID) return q.size() < 2;
    return out_ready || (q.size() == 0);
  endfunction

  function automatic logic [31:0] model_data();
    if (q.size() != 0) return q[0];
    return last_out;
  endfunction

  // Model update on each edge from the inputs held during the cycle.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      last_out = RV;
    end else begin
      m_ir = model_in_ready();
      if (flush) begin
        q.delete();
        last_out = RV;
      end else begin
        if (q.size() != 0 && out_ready) last_out = q.pop_front();
        if (in_valid && m_ir) q.push_back(in_data);
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("out_data", out_data, model_data());
      chk("occ", {30'b0, occ}, q.size());
      chk("in_ready", {31'b0, in_ready}, {31'b0, model_in_ready()});
      chk("occ_bound", {31'b0, occ <= 2'd2}, 32'd1);
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset asserted asynchronously while a payload is in flight.
    drive(1'b1, 32'h11, 1'b1, 1'b0);
    drive(1'b1, 32'h22, 1'b1, 1'b0);
    #3 RST = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'hDEADBEEF);
    chk("rst_occ", {30'b0, occ}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    RST = 1'b0;
    #3;
    chk("rel_out_data", out_data, 32'hDEADBEEF);
    chk("rel_out_valid", {31'b0, out_valid}, 32'd0);

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      #3;
      if (i > 1) chk("stream_data", out_data, i - 1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("stream_last", out_data, 32'd8);
    chk("stream_last_v", {31'b0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("empty_holds_last", out_data, 32'd8);
    chk("empty_valid", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure into the skid slot, then drain.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    #3;
    chk("bp_occ1", {30'b0, occ}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("bp_occ2", {30'b0, occ}, 32'd2);
    chk("bp_in_ready0", {31'b0, in_ready}, 32'd0);
    chk("bp_head", out_data, 32'hA);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("bp_a_out", out_data, 32'hA);
    chk("bp_still_full", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("bp_b_out", out_data, 32'hB);
    chk("bp_in_ready1", {31'b0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("bp_drained", {30'b0, occ}, 32'd0);

    // Flush while FULL with a payload offered.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b1);
    #3;
    chk("fl_full_occ", {30'b0, occ}, 32'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("fl_full_after_occ", {30'b0, occ}, 32'd0);
    chk("fl_full_after_v", {31'b0, out_valid}, 32'd0);
    chk("fl_full_after_d", out_data, 32'hDEADBEEF);
`else
    // Single-slot: ready follows out_ready combinationally.
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    drive(1'b1, 32'h6, 1'b0, 1'b0);
    #3;
    chk("ns_in_ready0", {31'b0, in_ready}, 32'd0);
    chk("ns_occ1", {30'b0, occ}, 32'd1);
    drive(1'b1, 32'h6, 1'b1, 1'b0);
    #3;
    chk("ns_in_ready1", {31'b0, in_ready}, 32'd1);
    chk("ns_head5", out_data, 32'h5);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("ns_replaced", out_data, 32'h6);
    chk("ns_occ_still1", {30'b0, occ}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`endif

    // Flush with a real input transfer in the same cycle: payload dropped.
    drive(1'b1, 32'hD, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("fl_occ", {30'b0, occ}, 32'd0);
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_data", out_data, 32'hDEADBEEF);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("fl_no_c", {31'b0, out_valid}, 32'd0);

    // Random valid/ready traffic with occasional flushes.
    for (int k = 0; k < 10000; k++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 97) == 0);
    end
    repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge CLK);
    #3;
    chk("final_empty", {30'b0, occ}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
